// File: rtl/ddr_wr_channel_ctrl.sv
// Packs user words into AXI beats, buffers them, and requests and streams fixed bursts to the write arbiter.
// Latency: a beat enters the FIFO one cycle after its last word. Backpressure: user_wr_full, plus the arbiter's wr_grant/wr_data_rd.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
            else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
        end
    end
endmodule

module ddr_wr_channel_ctrl #(
    parameter int          USER_WIDTH  = 16,
    parameter int          AXI_WIDTH   = 64,
    parameter int          FIFO_DEPTH  = 512,
    parameter int          BURST_BEATS = 64,
    parameter logic [29:0] WR_BEG_ADDR = 30'd0,
    parameter logic [29:0] WR_END_ADDR = 30'd2097152
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          user_wr_en,
    input  logic [USER_WIDTH-1:0]         user_wr_data,
    output logic                          user_wr_full,
    input  logic                          wr_addr_clr,
    output logic                          wr_req,
    input  logic                          wr_grant,
    output logic [29:0]                   wr_addr,
    output logic [7:0]                    wr_len,
    output logic [AXI_WIDTH-1:0]          wr_data,
    input  logic                          wr_data_rd,
    input  logic                          wr_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overflow
);
    localparam int RATIO = AXI_WIDTH / USER_WIDTH;
    localparam int WCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [29:0] BURST_BYTES = 30'(BURST_BEATS * AXI_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

    state_t                state;
    logic [WCW-1:0]        word_cnt;
    logic [AXI_WIDTH-1:0]  pack_dat;
    logic                  push_vld;
    logic                  clr_pend;
    logic [8:0]            beat_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  do_clr;
    logic                  addr_wrap;
    logic [29:0]           addr_nxt;

    assign wr_len       = 8'(BURST_BEATS - 1);
    assign user_wr_full = fifo_full;

    // A clear requested mid-burst waits for wr_done so the granted burst still completes.
    assign do_clr = (wr_addr_clr && state != BURST)
                 || (state == BURST && wr_done && (clr_pend || wr_addr_clr));

    assign pop = wr_data_rd && wr_grant && (state == BURST)
              && (beat_cnt < 9'(BURST_BEATS)) && !fifo_empty;

    assign addr_wrap = ({2'b00, wr_addr} + {1'b0, BURST_BYTES, 1'b0}) > {2'b00, WR_END_ADDR};
    assign addr_nxt  = addr_wrap ? WR_BEG_ADDR : (wr_addr + BURST_BYTES);

    sync_fifo #(
        .WIDTH (AXI_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (do_clr),
        .push  (push_vld),
        .din   (pack_dat),
        .pop   (pop),
        .dout  (wr_data),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            pack_dat <= '0;
            push_vld <= 1'b0;
            overflow <= 1'b0;
        end else if (do_clr) begin
            word_cnt <= '0;
            pack_dat <= '0;
            push_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            push_vld <= user_wr_en && (word_cnt == WCW'(RATIO - 1));
            if (user_wr_en) begin
                pack_dat[int'(word_cnt) * USER_WIDTH +: USER_WIDTH] <= user_wr_data;
                word_cnt <= (word_cnt == WCW'(RATIO - 1)) ? '0 : word_cnt + 1'b1;
            end
            if (push_vld && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_req   <= 1'b0;
            beat_cnt <= '0;
            clr_pend <= 1'b0;
            wr_addr  <= WR_BEG_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_addr_clr) begin
                        wr_addr <= WR_BEG_ADDR;
                    end else if (fifo_cnt >= CW'(BURST_BEATS)) begin
                        state  <= REQ;
                        wr_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (wr_addr_clr) begin
                        state   <= IDLE;
                        wr_req  <= 1'b0;
                        wr_addr <= WR_BEG_ADDR;
                    end else if (wr_grant) begin
                        state    <= BURST;
                        wr_req   <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (pop) beat_cnt <= beat_cnt + 1'b1;
                    if (wr_addr_clr) clr_pend <= 1'b1;
                    if (wr_done) begin
                        state    <= IDLE;
                        clr_pend <= 1'b0;
                        wr_addr  <= (clr_pend || wr_addr_clr) ? WR_BEG_ADDR : addr_nxt;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wr_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_wr_channel_ctrl.sv
// Directed bench: packing vectors from a table, then burst, wrap, overflow, clear and reset sequences.
module tb_ddr_wr_channel_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        user_wr_en;
    logic [15:0] user_wr_data;
    logic        user_wr_full;
    logic        wr_addr_clr;
    logic        wr_req;
    logic        wr_grant;
    logic [29:0] wr_addr;
    logic [7:0]  wr_len;
    logic [63:0] wr_data;
    logic        wr_data_rd;
    logic        wr_done;
    logic [3:0]  fifo_cnt;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    ddr_wr_channel_ctrl #(
        .USER_WIDTH  (16),
        .AXI_WIDTH   (64),
        .FIFO_DEPTH  (8),
        .BURST_BEATS (4),
        .WR_BEG_ADDR (30'd0),
        .WR_END_ADDR (30'd64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .user_wr_en   (user_wr_en),
        .user_wr_data (user_wr_data),
        .user_wr_full (user_wr_full),
        .wr_addr_clr  (wr_addr_clr),
        .wr_req       (wr_req),
        .wr_grant     (wr_grant),
        .wr_addr      (wr_addr),
        .wr_len       (wr_len),
        .wr_data      (wr_data),
        .wr_data_rd   (wr_data_rd),
        .wr_done      (wr_done),
        .fifo_cnt     (fifo_cnt),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w0, w1, w2, w3;
        logic        gap;
        logic [63:0] beat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d, input logic gap);
        user_wr_en   = 1'b1;
        user_wr_data = d;
        tick();
        user_wr_en = 1'b0;
        if (gap) tick();
    endtask

    task automatic push_beat(input logic [15:0] base);
        for (int i = 0; i < 4; i++) push_word(base + 16'(i), 1'b0);
    endtask

    function automatic logic [63:0] beat_of(input logic [15:0] base);
        return {base + 16'd3, base + 16'd2, base + 16'd1, base};
    endfunction

    task automatic wait_req(input string name);
        int n = 0;
        while (!wr_req && n < 20) begin
            tick();
            n++;
        end
        chk(name, wr_req, 1);
    endtask

    task automatic run_burst(input logic [15:0] base, input logic [29:0] exp_addr, input string tag);
        for (int b = 0; b < 4; b++) push_beat(base + 16'(4 * b));
        wait_req({tag, "_req"});
        chk({tag, "_addr"}, wr_addr, exp_addr);
        wr_grant = 1'b1;
        tick();
        chk({tag, "_req_drop"}, wr_req, 0);
        wr_data_rd = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_data"}, wr_data, beat_of(base + 16'(4 * b)));
            tick();
        end
        wr_data_rd = 1'b0;
        wr_done    = 1'b1;
        tick();
        wr_done  = 1'b0;
        wr_grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, 64'h0004_0003_0002_0001};
        vecs[1] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 1'b1, 64'h0000_FFFF_5555_AAAA};
        vecs[2] = '{16'h1234, 16'h0000, 16'h0000, 16'hABCD, 1'b0, 64'hABCD_0000_0000_1234};
        vecs[3] = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 1'b1, 64'hF00D_CAFE_BEEF_DEAD};

        rst = 1'b1; user_wr_en = 1'b0; user_wr_data = '0; wr_addr_clr = 1'b0;
        wr_grant = 1'b0; wr_data_rd = 1'b0; wr_done = 1'b0;
        tick(); tick();
        chk("rst_req", wr_req, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_full", user_wr_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", wr_addr, 0);
        rst = 1'b0;
        tick();
        chk("wr_len", wr_len, 3);

        // packing vectors: one beat each, then cleared from IDLE
        for (int v = 0; v < 4; v++) begin
            push_word(vecs[v].w0, vecs[v].gap);
            push_word(vecs[v].w1, vecs[v].gap);
            push_word(vecs[v].w2, vecs[v].gap);
            push_word(vecs[v].w3, 1'b0);
            chk("vec_not_yet", fifo_cnt, 0);
            tick();
            chk("vec_cnt", fifo_cnt, 1);
            chk("vec_beat", wr_data, vecs[v].beat);
            chk("vec_noreq", wr_req, 0);
            wr_addr_clr = 1'b1;
            tick();
            wr_addr_clr = 1'b0;
            chk("vec_clr_cnt", fifo_cnt, 0);
        end

        // T1: 16 words -> 4 beats, request follows
        for (int i = 1; i <= 16; i++) push_word(16'(i), 1'b0);
        tick();
        chk("t1_cnt", fifo_cnt, 4);
        chk("t1_req_early", wr_req, 0);
        tick();
        chk("t1_req", wr_req, 1);
        chk("t1_head", wr_data, 64'h0004_0003_0002_0001);

        // T2: late grant, 4 pops, done
        tick(); tick();
        chk("t2_req_hold", wr_req, 1);
        wr_grant = 1'b1;
        chk("t2_req_grant_cycle", wr_req, 1);
        tick();
        chk("t2_req_drop", wr_req, 0);
        chk("t2_addr_stable", wr_addr, 0);
        wr_data_rd = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("t2_data", wr_data, beat_of(16'(1 + 4 * b)));
            tick();
        end
        chk("t2_cnt_empty", fifo_cnt, 0);
        chk("t2_addr_mid", wr_addr, 0);
        wr_data_rd = 1'b0;
        wr_done    = 1'b1;
        tick();
        wr_done  = 1'b0;
        wr_grant = 1'b0;
        chk("t2_addr", wr_addr, 32);
        tick(); tick();
        chk("t2_idle", wr_req, 0);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("idle_done_ignored", wr_addr, 32);

        // T3: wrap with END=64
        run_burst(16'h0100, 30'd32, "t3b2");
        chk("t3_wrap", wr_addr, 0);
        run_burst(16'h0200, 30'd0, "t3b3");
        chk("t3_addr3", wr_addr, 32);

        // T4: overflow
        for (int b = 0; b < 8; b++) push_beat(16'h0300 + 16'(4 * b));
        tick(); tick();
        chk("t4_cnt_full", fifo_cnt, 8);
        chk("t4_full", user_wr_full, 1);
        chk("t4_no_ovf", overflow, 0);
        push_beat(16'h0400);
        tick(); tick();
        chk("t4_ovf", overflow, 1);
        chk("t4_cnt_held", fifo_cnt, 8);
        chk("t4_head", wr_data, beat_of(16'h0300));
        wr_addr_clr = 1'b1;
        tick();
        wr_addr_clr = 1'b0;
        chk("t4_clr_cnt", fifo_cnt, 0);
        chk("t4_clr_ovf", overflow, 0);
        chk("t4_clr_full", user_wr_full, 0);
        chk("t4_clr_req", wr_req, 0);
        chk("t4_clr_addr", wr_addr, 0);

        // T5: clear during a burst
        for (int b = 0; b < 4; b++) push_beat(16'h0500 + 16'(4 * b));
        wait_req("t5_req");
        wr_grant = 1'b1;
        tick();
        wr_data_rd  = 1'b1;
        wr_addr_clr = 1'b1;
        chk("t5_data", wr_data, beat_of(16'h0500));
        tick();
        wr_addr_clr = 1'b0;
        for (int b = 1; b < 4; b++) begin
            chk("t5_data", wr_data, beat_of(16'h0500 + 16'(4 * b)));
            tick();
        end
        push_beat(16'h0600);
        tick();
        chk("t5_pops_stop", fifo_cnt, 1);
        chk("t5_addr_hold", wr_addr, 0);
        wr_data_rd = 1'b0;
        wr_done    = 1'b1;
        tick();
        wr_done  = 1'b0;
        wr_grant = 1'b0;
        tick();
        chk("t5_addr", wr_addr, 0);
        chk("t5_cnt", fifo_cnt, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_req", wr_req, 0);

        // T6: async reset mid-burst
        run_burst(16'h0800, 30'd0, "t6pre");
        chk("t6_addr_pre", wr_addr, 32);
        for (int b = 0; b < 4; b++) push_beat(16'h0900 + 16'(4 * b));
        wait_req("t6_req");
        wr_grant = 1'b1;
        tick();
        wr_data_rd = 1'b1;
        tick(); tick();
        chk("t6_cnt_pre", fifo_cnt, 2);
        rst = 1'b1;
        #1;
        chk("t6_req", wr_req, 0);
        chk("t6_cnt", fifo_cnt, 0);
        chk("t6_addr", wr_addr, 0);
        chk("t6_full", user_wr_full, 0);
        wr_data_rd = 1'b0;
        wr_grant   = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_after", fifo_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
